softusb_irqctl: RTL and testbench
=================================

Name: softusb_irqctl

Overview:
- Interrupt controller for the softusb navre CPU subsystem; it is the receiving end of the peripheral irq/irq_ack handshake that softusb_timer and the other softusb peripherals drive.
- Detects rising edges on peripheral irq lines, latches them as pending, masks and prioritises them, and presents one request plus vector to the CPU.
- When the CPU accepts the interrupt, it returns a one-cycle irq_ack pulse to the winning source.
- Sits on the softusb 6-bit IO bus beside the timer.

Parameters:
- NIRQ, 4, number of interrupt sources (1..8).
- BASE, 6'h28, IO address of register 0; registers occupy BASE..BASE+2.

Ports:
- usb_clk  in  1  system clock; all logic on rising edge.
- usb_rst_n  in  1  asynchronous active-low reset.
- io_we  in  1  IO write strobe, one cycle.
- io_a  in  6  IO address.
- io_di  in  8  IO write data.
- io_do  out  8  IO read data, registered.
- irq_src  in  NIRQ  peripheral interrupt lines (level; rising edge = event).
- irq_ack  out  NIRQ  one-hot acknowledge pulse back to the source.
- cpu_irq  out  1  interrupt request to the CPU.
- cpu_vector  out  3  index of the requested source.
- cpu_ack  in  1  CPU takes the interrupt, one-cycle pulse.
- cpu_reti  in  1  CPU executed RETI, one-cycle pulse.

Behaviour:
- Registers:
  - BASE+0 IMASK: r/w, bits [NIRQ-1:0], 1 = enabled.
  - BASE+1 IPEND: read-only pending bits. Writes are ignored.
  - BASE+2 ICTL: bit0 GIE (r/w); bit1 in-service flag (read-only).
  - Unused bits read 0. Other addresses: io_do = 0.
- io_do is registered: data for io_a in cycle N appears in cycle N+1.
- Edge detect: an irq_src_r register holds the previous sample. Event[i] = irq_src[i] & ~irq_src_r[i]. An event sets pend[i] on the next edge.
- Reset values: IMASK=0, pend=0, GIE=0, irq_src_r=0, io_do=0, irq_ack=0, cpu_irq=0, cpu_vector=0, state=IDLE.
- Eligible set = pend & IMASK, gated by GIE. Winner = lowest eligible index.
- FSM states:
  - IDLE: if the eligible set is non-empty, latch the winner into cpu_vector, set cpu_irq=1 and go to REQ. Latency from the irq_src rising edge to cpu_irq high is 2 cycles (edge detect, then pend).
  - REQ: cpu_irq stays 1 and cpu_vector is held stable.
    - On cpu_ack: the next cycle drives irq_ack[cpu_vector]=1 for exactly one cycle, clears pend[cpu_vector], sets cpu_irq=0, and enters SERVICE.
    - If pend[cpu_vector] becomes masked, or GIE is cleared, with no cpu_ack in that cycle: cpu_irq=0 and return to IDLE, withdrawing the request. cpu_ack in the same cycle as the withdrawal is honoured.
    - A higher-priority event arriving in REQ does not change cpu_vector.
  - SERVICE: no new request (no nesting).
    - On cpu_reti: go to IDLE. A new request may assert on the following cycle.
    - cpu_ack in SERVICE or IDLE is ignored.
- Simultaneous clear and new event on the same bit: set wins, and the bit stays pending.
- An event on a masked source still sets pend; it is taken once unmasked.
- A repeated event while already pending is merged; there is no counting.
- A write to IMASK/ICTL and a state transition in the same cycle: the new register value is used from the next cycle.
- cpu_reti in IDLE or REQ is ignored.
- Asynchronous reset at any point returns all state to the reset values immediately. An in-flight irq_ack pulse is cut short.

Test Plan:
- Reset, write IMASK=0x01 and ICTL=0x01, raise irq_src[0] -> cpu_irq=1 and cpu_vector=0 two cycles later. Pulse cpu_ack -> irq_ack=4'b0001 for one cycle, IPEND reads 0x00, ICTL reads 0x03. Pulse cpu_reti -> ICTL reads 0x01.
- IMASK=0x0F, GIE=1, raise irq_src[3] and irq_src[1] in the same cycle -> cpu_vector=1. After ack and reti -> cpu_vector=3 and cpu_irq=1 again.
- GIE=0, raise irq_src[2] -> IPEND=0x04, cpu_irq stays 0. Write GIE=1 -> cpu_irq=1 and cpu_vector=2 within 2 cycles.
- In REQ for vector 0, write IMASK=0x00 -> cpu_irq=0 next cycle, state returns to IDLE, and IPEND still reads 0x01.
- In SERVICE, raise irq_src[1] -> IPEND=0x02 and cpu_irq stays 0 until cpu_reti. Raise irq_src[0] on the same cycle its pend clears from an ack -> IPEND bit0 remains 1.
- Drive usb_rst_n low asynchronously mid-REQ -> cpu_irq, irq_ack, IPEND, IMASK and io_do are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/softusb_irqctl.sv
// softusb_irqctl: edge-triggered interrupt controller for the softusb navre CPU.
// Latches irq_src rising edges as pending, masks/prioritises them and runs the cpu_ack/cpu_reti handshake.
module softusb_irqctl #(
    parameter int         NIRQ = 4,
    parameter logic [5:0] BASE = 6'h28
) (
    input  logic            usb_clk,
    input  logic            usb_rst_n,
    input  logic            io_we,
    input  logic [5:0]      io_a,
    input  logic [7:0]      io_di,
    output logic [7:0]      io_do,
    input  logic [NIRQ-1:0] irq_src,
    output logic [NIRQ-1:0] irq_ack,
    output logic            cpu_irq,
    output logic [2:0]      cpu_vector,
    input  logic            cpu_ack,
    input  logic            cpu_reti
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    localparam logic [NIRQ-1:0] ONE = NIRQ'(1);

    state_t          state_q, state_d;
    logic [NIRQ-1:0] src_r_q, pend_q, pend_d, imask_q, imask_d, irq_ack_q, irq_ack_d;
    logic [NIRQ-1:0] evt, elig, vec_oh, clr;
    logic            gie_q, gie_d, cpu_irq_q, cpu_irq_d;
    logic [2:0]      vec_q, vec_d, win;
    logic [7:0]      io_do_q, io_do_d;
    logic            unused_di;

    assign unused_di  = ^io_di;
    assign evt        = irq_src & ~src_r_q;
    assign elig       = gie_q ? (pend_q & imask_q) : '0;
    assign vec_oh     = ONE << vec_q;
    assign io_do      = io_do_q;
    assign irq_ack    = irq_ack_q;
    assign cpu_irq    = cpu_irq_q;
    assign cpu_vector = vec_q;

    always_comb begin
        win = '0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (elig[i]) win = 3'(i);
    end

    always_comb begin
        state_d   = state_q;
        cpu_irq_d = cpu_irq_q;
        vec_d     = vec_q;
        irq_ack_d = '0;
        clr       = '0;
        case (state_q)
            IDLE: if (|elig) begin
                state_d   = REQ;
                cpu_irq_d = 1'b1;
                vec_d     = win;
            end
            REQ: if (cpu_ack) begin
                state_d   = SERVICE;
                cpu_irq_d = 1'b0;
                irq_ack_d = vec_oh;
                clr       = vec_oh;
            end else if (!gie_q || !(|(imask_q & vec_oh))) begin
                state_d   = IDLE;
                cpu_irq_d = 1'b0;
            end
            SERVICE: if (cpu_reti) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new edge in the same cycle as an ack-clear keeps the bit pending.
    always_comb begin
        pend_d  = (pend_q & ~clr) | evt;
        imask_d = (io_we && io_a == BASE) ? io_di[NIRQ-1:0] : imask_q;
        gie_d   = (io_we && io_a == BASE + 6'd2) ? io_di[0] : gie_q;
        io_do_d = io_a == BASE ? 8'(imask_q) :
                  io_a == BASE + 6'd1 ? 8'(pend_q) :
                  io_a == BASE + 6'd2 ? {6'd0, state_q == SERVICE, gie_q} : 8'd0;
    end

    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            state_q   <= IDLE;
            src_r_q   <= '0;
            pend_q    <= '0;
            imask_q   <= '0;
            gie_q     <= 1'b0;
            irq_ack_q <= '0;
            cpu_irq_q <= 1'b0;
            vec_q     <= '0;
            io_do_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_r_q   <= irq_src;
            pend_q    <= pend_d;
            imask_q   <= imask_d;
            gie_q     <= gie_d;
            irq_ack_q <= irq_ack_d;
            cpu_irq_q <= cpu_irq_d;
            vec_q     <= vec_d;
            io_do_q   <= io_do_d;
        end
    end
endmodule

// File: tb/tb_softusb_irqctl.sv
// tb_softusb_irqctl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_softusb_irqctl;
    localparam logic [5:0] BASE = 6'h28;

    logic       usb_clk = 1'b0, usb_rst_n = 1'b0, io_we = 1'b0, cpu_ack = 1'b0, cpu_reti = 1'b0;
    logic [5:0] io_a = '0;
    logic [7:0] io_di = '0, io_do;
    logic [3:0] irq_src = '0, irq_ack;
    logic       cpu_irq;
    logic [2:0] cpu_vector;
    int         vectors = 0, miscompares = 0;

    // behavioural model state
    logic [3:0] m_src_r, m_pend, m_mask, m_ack;
    logic       m_gie, m_req, m_svc;
    int         m_vec;
    logic [7:0] m_do;

    softusb_irqctl #(.NIRQ(4), .BASE(BASE)) dut (
        .usb_clk(usb_clk), .usb_rst_n(usb_rst_n), .io_we(io_we), .io_a(io_a), .io_di(io_di),
        .io_do(io_do), .irq_src(irq_src), .irq_ack(irq_ack), .cpu_irq(cpu_irq),
        .cpu_vector(cpu_vector), .cpu_ack(cpu_ack), .cpu_reti(cpu_reti)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic model_reset();
        m_src_r = '0; m_pend = '0; m_mask = '0; m_ack = '0;
        m_gie = 0; m_req = 0; m_svc = 0; m_vec = 0; m_do = '0;
    endtask

    // Advance one clock; the model consumes the inputs held across the edge. Returns 1 time unit after the edge.
    task automatic step();
        logic [3:0] ev, elig, low, clr;
        logic [7:0] rd;
        @(posedge usb_clk);
        ev   = irq_src & ~m_src_r;
        elig = m_gie ? (m_pend & m_mask) : 4'd0;
        low  = elig & (~elig + 4'd1);
        rd   = io_a == BASE ? {4'd0, m_mask} : io_a == BASE + 6'd1 ? {4'd0, m_pend} :
               io_a == BASE + 6'd2 ? {6'd0, m_svc, m_gie} : 8'd0;
        clr  = '0;
        m_ack = '0;
        if (m_svc) begin
            if (cpu_reti) m_svc = 0;
        end else if (m_req) begin
            if (cpu_ack) begin
                clr = 4'd1 << m_vec; m_ack = clr; m_req = 0; m_svc = 1;
            end else if (!m_gie || !m_mask[m_vec]) m_req = 0;
        end else if (elig != 0) begin
            m_req = 1; m_vec = $clog2(low);
        end
        m_pend = (m_pend & ~clr) | ev;
        if (io_we && io_a == BASE) m_mask = io_di[3:0];
        if (io_we && io_a == BASE + 6'd2) m_gie = io_di[0];
        m_src_r = irq_src;
        m_do = rd;
        #1;
    endtask

    task automatic do_reset();
        usb_rst_n = 0;
        io_we = 0; io_a = '0; io_di = '0; irq_src = '0; cpu_ack = 0; cpu_reti = 0;
        model_reset();
        repeat (2) @(posedge usb_clk);
        #1 usb_rst_n = 1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_we = 1; io_a = a; io_di = d;
        step();
        io_we = 0;
    endtask

    task automatic pulse_ack();
        cpu_ack = 1; step(); cpu_ack = 0;
    endtask

    task automatic pulse_reti();
        cpu_reti = 1; step(); cpu_reti = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (cpu_irq !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_irq: got %b want 0", cpu_irq); end
        vectors++; if (irq_ack !== 4'd0) begin miscompares++; $display("FAIL rst_irq_ack: got %b want 0000", irq_ack); end
        vectors++; if (cpu_vector !== 3'd0) begin miscompares++; $display("FAIL rst_vector: got %0d want 0", cpu_vector); end
        vectors++; if (io_do !== 8'd0) begin miscompares++; $display("FAIL rst_io_do: got %h want 00", io_do); end
        io_a = BASE; step();
        vectors++; if (io_do !== 8'd0) begin miscompares++; $display("FAIL rst_imask: got %h want 00", io_do); end
    endtask

    task automatic test_basic();
        do_reset();
        wr(BASE, 8'h01); wr(BASE + 6'd2, 8'h01);
        irq_src = 4'b0001; step();
        vectors++; if (cpu_irq !== 1'b0) begin miscompares++; $display("FAIL basic_early: got %b want 0", cpu_irq); end
        step();
        vectors++; if (cpu_irq !== 1'b1) begin miscompares++; $display("FAIL basic_irq: got %b want 1", cpu_irq); end
        vectors++; if (cpu_vector !== 3'd0) begin miscompares++; $display("FAIL basic_vec: got %0d want 0", cpu_vector); end
        pulse_ack();
        vectors++; if (irq_ack !== 4'b0001) begin miscompares++; $display("FAIL basic_ack: got %b want 0001", irq_ack); end
        vectors++; if (cpu_irq !== 1'b0) begin miscompares++; $display("FAIL basic_irq_drop: got %b want 0", cpu_irq); end
        io_a = BASE + 6'd1; step();
        vectors++; if (irq_ack !== 4'b0000) begin miscompares++; $display("FAIL basic_ack_len: got %b want 0000", irq_ack); end
        vectors++; if (io_do !== 8'h00) begin miscompares++; $display("FAIL basic_ipend: got %h want 00", io_do); end
        io_a = BASE + 6'd2; step();
        vectors++; if (io_do !== 8'h03) begin miscompares++; $display("FAIL basic_ictl_svc: got %h want 03", io_do); end
        pulse_reti(); step();
        vectors++; if (io_do !== 8'h01) begin miscompares++; $display("FAIL basic_ictl_idle: got %h want 01", io_do); end
        irq_src = '0;
    endtask

    task automatic test_priority();
        do_reset();
        wr(BASE, 8'h0F); wr(BASE + 6'd2, 8'h01);
        irq_src = 4'b1010; step(); step();
        vectors++; if (cpu_vector !== 3'd1) begin miscompares++; $display("FAIL prio_vec1: got %0d want 1", cpu_vector); end
        pulse_ack();
        vectors++; if (irq_ack !== 4'b0010) begin miscompares++; $display("FAIL prio_ack1: got %b want 0010", irq_ack); end
        pulse_reti(); step();
        vectors++; if (cpu_irq !== 1'b1) begin miscompares++; $display("FAIL prio_irq3: got %b want 1", cpu_irq); end
        vectors++; if (cpu_vector !== 3'd3) begin miscompares++; $display("FAIL prio_vec3: got %0d want 3", cpu_vector); end
        irq_src = '0;
    endtask

    task automatic test_gie();
        do_reset();
        wr(BASE, 8'h0F);
        irq_src = 4'b0100; step(); step();
        io_a = BASE + 6'd1; step();
        vectors++; if (io_do !== 8'h04) begin miscompares++; $display("FAIL gie_ipend: got %h want 04", io_do); end
        vectors++; if (cpu_irq !== 1'b0) begin miscompares++; $display("FAIL gie_off_irq: got %b want 0", cpu_irq); end
        wr(BASE + 6'd2, 8'h01); step();
        vectors++; if (cpu_irq !== 1'b1) begin miscompares++; $display("FAIL gie_on_irq: got %b want 1", cpu_irq); end
        vectors++; if (cpu_vector !== 3'd2) begin miscompares++; $display("FAIL gie_on_vec: got %0d want 2", cpu_vector); end
        irq_src = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        wr(BASE, 8'h01); wr(BASE + 6'd2, 8'h01);
        irq_src = 4'b0001; step(); step();
        wr(BASE, 8'h00);
        vectors++; if (cpu_irq !== 1'b1) begin miscompares++; $display("FAIL wd_hold: got %b want 1", cpu_irq); end
        io_a = BASE + 6'd1; step();
        vectors++; if (cpu_irq !== 1'b0) begin miscompares++; $display("FAIL wd_drop: got %b want 0", cpu_irq); end
        step();
        vectors++; if (io_do !== 8'h01) begin miscompares++; $display("FAIL wd_ipend: got %h want 01", io_do); end
        io_a = BASE + 6'd2; step();
        vectors++; if (io_do !== 8'h01) begin miscompares++; $display("FAIL wd_ictl: got %h want 01", io_do); end
        wr(BASE, 8'h01); step();
        vectors++; if (cpu_irq !== 1'b1) begin miscompares++; $display("FAIL wd_rereq: got %b want 1", cpu_irq); end
        irq_src = '0;
    endtask

    task automatic test_service();
        do_reset();
        wr(BASE, 8'h0F); wr(BASE + 6'd2, 8'h01);
        irq_src = 4'b0001; step(); step();
        pulse_ack();
        irq_src = 4'b0011; step(); step();
        io_a = BASE + 6'd1; step();
        vectors++; if (io_do !== 8'h02) begin miscompares++; $display("FAIL svc_ipend: got %h want 02", io_do); end
        vectors++; if (cpu_irq !== 1'b0) begin miscompares++; $display("FAIL svc_nonest: got %b want 0", cpu_irq); end
        pulse_reti(); step();
        vectors++; if (cpu_irq !== 1'b1) begin miscompares++; $display("FAIL svc_after_reti: got %b want 1", cpu_irq); end
        vectors++; if (cpu_vector !== 3'd1) begin miscompares++; $display("FAIL svc_vec: got %0d want 1", cpu_vector); end
        irq_src = 4'b0001; step();
        irq_src = 4'b0011; pulse_ack();
        vectors++; if (irq_ack !== 4'b0010) begin miscompares++; $display("FAIL setwin_ack: got %b want 0010", irq_ack); end
        step();
        vectors++; if (io_do !== 8'h02) begin miscompares++; $display("FAIL setwin_ipend: got %h want 02", io_do); end
        irq_src = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(BASE, 8'h0F); wr(BASE + 6'd2, 8'h01);
        io_a = BASE; irq_src = 4'b0001; step(); step();
        vectors++; if (cpu_irq !== 1'b1 || io_do !== 8'h0F) begin miscompares++; $display("FAIL ar_pre: got irq=%b do=%h want 1/0f", cpu_irq, io_do); end
        #2 usb_rst_n = 0; irq_src = '0;
        #1;
        vectors++; if (cpu_irq !== 1'b0) begin miscompares++; $display("FAIL ar_irq: got %b want 0", cpu_irq); end
        vectors++; if (io_do !== 8'h00) begin miscompares++; $display("FAIL ar_io_do: got %h want 00", io_do); end
        do_reset();
        io_a = BASE; step();
        vectors++; if (io_do !== 8'h00) begin miscompares++; $display("FAIL ar_imask: got %h want 00", io_do); end
        io_a = BASE + 6'd1; step();
        vectors++; if (io_do !== 8'h00) begin miscompares++; $display("FAIL ar_ipend: got %h want 00", io_do); end
        wr(BASE, 8'h01); wr(BASE + 6'd2, 8'h01);
        irq_src = 4'b0001; step(); step();
        pulse_ack();
        vectors++; if (irq_ack !== 4'b0001) begin miscompares++; $display("FAIL ar_ack_pre: got %b want 0001", irq_ack); end
        #2 usb_rst_n = 0; irq_src = '0;
        #1;
        vectors++; if (irq_ack !== 4'b0000) begin miscompares++; $display("FAIL ar_ack_cut: got %b want 0000", irq_ack); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        wr(BASE, 8'h0F); wr(BASE + 6'd2, 8'h01);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) irq_src = 4'($urandom_range(0, 15));
            cpu_ack  = $urandom_range(0, 3) == 0;
            cpu_reti = $urandom_range(0, 3) == 0;
            io_we    = $urandom_range(0, 9) == 0;
            io_a     = $urandom_range(0, 7) == 0 ? 6'($urandom) : BASE + 6'($urandom_range(0, 3));
            io_di    = 8'($urandom);
            if (io_we && io_a == BASE + 6'd2 && $urandom_range(0, 3) != 0) io_di[0] = 1'b1;
            step();
            vectors++; if (cpu_irq !== m_req) begin miscompares++; $display("FAIL rnd_irq @%0d: got %b want %b", n, cpu_irq, m_req); end
            vectors++; if (cpu_vector !== 3'(m_vec)) begin miscompares++; $display("FAIL rnd_vec @%0d: got %0d want %0d", n, cpu_vector, m_vec); end
            vectors++; if (irq_ack !== m_ack) begin miscompares++; $display("FAIL rnd_ack @%0d: got %b want %b", n, irq_ack, m_ack); end
            vectors++; if (io_do !== m_do) begin miscompares++; $display("FAIL rnd_io_do @%0d: got %h want %h", n, io_do, m_do); end
        end
        io_we = 0; cpu_ack = 0; cpu_reti = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_gie();
        test_withdraw();
        test_service();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
